polar_peak_finder: RTL

POLAR_PEAK_FINDER -- requirements
Module: polar_peak_finder

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/polar_peak_finder_if.sv | 43 ++++
 rtl/polar_peak_finder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and sizes for the CORDIC polar back-end blocks.
// Used by polar_peak_finder and its bus interface.
package cordic_pkg;

  localparam int MAG_W       = 12;    // 4.8 unsigned magnitude
  localparam int PH_W        = 21;    // 1.20 unsigned phase, 1.0 = 180 deg
  localparam int IDX_W       = 10;    // sample index inside a burst
  localparam int CNT_W       = 11;    // sample count, 0..1024
  localparam int MAX_SAMPLES = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Unsigned threshold test shared by the first-sample load and accumulation.
  function automatic logic mag_at_least(input logic [MAG_W-1:0] mag,
                                        input logic [MAG_W-1:0] thr);
    return (mag >= thr);
  endfunction

  // Counter step that only advances when the qualifying condition holds.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic             en);
    return cnt + CNT_W'(en);
  endfunction

endpackage

// File: rtl/polar_peak_finder_if.sv
// Sample-in / result-out bus of polar_peak_finder.
// The slave modport is the peak finder itself; the master modport is the
// environment that supplies samples and consumes results.
// Optional macro PEAK_PHASE_DELTA_EN adds the out_dphase result field.
interface polar_peak_finder_if;
  import cordic_pkg::*;

  logic             in_valid;
  logic [MAG_W-1:0] in_mag;
  logic [PH_W-1:0]  in_phase;
  logic [MAG_W-1:0] thr;
  logic             out_ready;

  logic             out_valid;
  logic [MAG_W-1:0] out_peak_mag;
  logic [PH_W-1:0]  out_peak_phase;
  logic [IDX_W-1:0] out_peak_idx;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_above;
  logic             out_sat;
`ifdef PEAK_PHASE_DELTA_EN
  logic [PH_W-1:0]  out_dphase;
`endif

  modport master (
    output in_valid, in_mag, in_phase, thr, out_ready,
    input  out_valid, out_peak_mag, out_peak_phase, out_peak_idx,
           out_count, out_above, out_sat
`ifdef PEAK_PHASE_DELTA_EN
    , input out_dphase
`endif
  );

  modport slave (
    input  in_valid, in_mag, in_phase, thr, out_ready,
    output out_valid, out_peak_mag, out_peak_phase, out_peak_idx,
           out_count, out_above, out_sat
`ifdef PEAK_PHASE_DELTA_EN
    , output out_dphase
`endif
  );

endinterface

// File: rtl/polar_peak_finder.sv
// Burst peak finder for CORDIC polar samples.
// Tracks the largest magnitude of a burst (first maximum wins a tie), its
// phase and index, the sample count (capped at 1024 with a sticky overflow
// flag) and how many samples reached the threshold latched on sample 0.
// The result is presented in HOLD until the consumer takes it; data
// outputs read as zero in every other state.
// Optional macro PEAK_PHASE_DELTA_EN adds out_dphase: the peak phase minus
// the phase of the preceding sample, wrapping natively at 21 bits.
module polar_peak_finder
  import cordic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  polar_peak_finder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SAMPLES);

  state_e           state_q, state_d;

  logic [MAG_W-1:0] thr_q;
  logic [MAG_W-1:0] peak_mag_q;
  logic [PH_W-1:0]  peak_phase_q;
  logic [IDX_W-1:0] peak_idx_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] above_q;
  logic             sat_q;
`ifdef PEAK_PHASE_DELTA_EN
  logic [PH_W-1:0]  prev_phase_q;
  logic [PH_W-1:0]  dphase_q;
`endif

  logic             full;
  logic             new_peak;
  logic             hold;

  // Once 1024 samples are in, later samples of the burst only flag overflow.
  assign full     = (count_q == CNT_MAX);
  // Strictly greater keeps the earliest of equal maxima.
  assign new_peak = (bus.in_mag > peak_mag_q);
  assign hold     = (state_q == HOLD);

  // Burst state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a burst opens from IDLE only, closes on the first gap, and
  // its result is released by out_ready; samples seen in HOLD are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = ACC;
      ACC:     if (!bus.in_valid) state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst accumulators: sample 0 loads everything, later samples update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q        <= '0;
      peak_mag_q   <= '0;
      peak_phase_q <= '0;
      peak_idx_q   <= '0;
      count_q      <= '0;
      above_q      <= '0;
      sat_q        <= 1'b0;
`ifdef PEAK_PHASE_DELTA_EN
      prev_phase_q <= '0;
      dphase_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            thr_q        <= bus.thr;
            peak_mag_q   <= bus.in_mag;
            peak_phase_q <= bus.in_phase;
            peak_idx_q   <= '0;
            count_q      <= CNT_W'(1);
            above_q      <= CNT_W'(mag_at_least(bus.in_mag, bus.thr));
            sat_q        <= 1'b0;
`ifdef PEAK_PHASE_DELTA_EN
            prev_phase_q <= bus.in_phase;
            dphase_q     <= '0;
`endif
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            if (full) begin
              sat_q <= 1'b1;
            end else begin
              count_q <= cnt_step(count_q, 1'b1);
              above_q <= cnt_step(above_q, mag_at_least(bus.in_mag, thr_q));
              if (new_peak) begin
                peak_mag_q   <= bus.in_mag;
                peak_phase_q <= bus.in_phase;
                // Index of this sample equals the count before it.
                peak_idx_q   <= count_q[IDX_W-1:0];
`ifdef PEAK_PHASE_DELTA_EN
                dphase_q     <= bus.in_phase - prev_phase_q;
`endif
              end
`ifdef PEAK_PHASE_DELTA_EN
              prev_phase_q <= bus.in_phase;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Result is only visible while it is being offered.
  assign bus.out_valid      = hold;
  assign bus.out_peak_mag   = hold ? peak_mag_q   : '0;
  assign bus.out_peak_phase = hold ? peak_phase_q : '0;
  assign bus.out_peak_idx   = hold ? peak_idx_q   : '0;
  assign bus.out_count      = hold ? count_q      : '0;
  assign bus.out_above      = hold ? above_q      : '0;
  assign bus.out_sat        = hold & sat_q;
`ifdef PEAK_PHASE_DELTA_EN
  assign bus.out_dphase     = hold ? dphase_q     : '0;
`endif

endmodule
